// File: rtl/bcd_sevenseg_scan_pkg.sv
// Shared constants for the three-digit multiplexed seven-segment scanner.
// Segment vectors are active-low in {g,f,e,d,c,b,a} order.
package bcd_sevenseg_scan_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Entry n is the pattern for decimal digit n (entry 0 sits in the low bits)
    localparam logic [9:0][6:0] DIGIT_SEG = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        DIG_UNITS    = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } digit_e;

endpackage

// File: rtl/bcd_sevenseg_scan_bcd_to_sevenseg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Codes 10-15 are not valid BCD and show a dash.
module bcd_to_sevenseg
    import bcd_sevenseg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup for valid digits, dash otherwise
    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = DIGIT_SEG[bcd];
        end else begin
            seg = SEG_DASH;
        end
    end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Time-multiplexed driver for three BCD digits on a common-anode display.
// bcd_in is sampled once per frame so a digit never tears mid-scan.
module bcd_sevenseg_scan
    import bcd_sevenseg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bcd_in,
    input  logic        blank_lz,
    output logic [2:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int             PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]  PRE_PENULT = PW'(REFRESH_DIV - 2);

    logic [PW-1:0] prescaler_r;
    digit_e        idx_r;
    logic [11:0]   frame_bcd_r;
    logic [2:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic          frame_tick_r;

    logic          slot_tick_s;
    digit_e        idx_next_s;
    logic [3:0]    nibble_s;
    logic          blank_s;
    logic [2:0]    an_next_s;
    logic [6:0]    dec_seg_s;
    logic [6:0]    seg_next_s;

    assign slot_tick_s = (prescaler_r == PRE_LAST);

    // Digit selection, leading-zero blanking and anode pattern for the current slot
    always_comb begin
        nibble_s   = 4'd0;
        blank_s    = 1'b0;
        an_next_s  = 3'b111;
        idx_next_s = DIG_UNITS;
        case (idx_r)
            DIG_UNITS: begin
                nibble_s   = frame_bcd_r[3:0];
                blank_s    = 1'b0;
                an_next_s  = 3'b110;
                idx_next_s = DIG_TENS;
            end
            DIG_TENS: begin
                nibble_s   = frame_bcd_r[7:4];
                blank_s    = blank_lz && (frame_bcd_r[11:8] == 4'd0) && (frame_bcd_r[7:4] == 4'd0);
                an_next_s  = 3'b101;
                idx_next_s = DIG_HUNDREDS;
            end
            DIG_HUNDREDS: begin
                nibble_s   = frame_bcd_r[11:8];
                blank_s    = blank_lz && (frame_bcd_r[11:8] == 4'd0);
                an_next_s  = 3'b011;
                idx_next_s = DIG_UNITS;
            end
            default: begin
                nibble_s   = frame_bcd_r[3:0];
                blank_s    = 1'b0;
                an_next_s  = 3'b111;
                idx_next_s = DIG_UNITS;
            end
        endcase
    end

    bcd_to_sevenseg u_dec (
        .bcd (nibble_s),
        .seg (dec_seg_s)
    );

    // Blanking only ever hides a zero, so a dash is never suppressed
    always_comb begin
        seg_next_s = dec_seg_s;
        if (blank_s) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = dec_seg_s;
        end
    end

    // Prescaler, scan index, frame shadow and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_r  <= '0;
            idx_r        <= DIG_UNITS;
            frame_bcd_r  <= 12'h000;
            an_r         <= 3'b111;
            seg_r        <= SEG_BLANK;
            dp_r         <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            if (slot_tick_s) begin
                prescaler_r <= '0;
                idx_r       <= idx_next_s;
            end else begin
                prescaler_r <= prescaler_r + 1'b1;
            end
            if (slot_tick_s && (idx_r == DIG_HUNDREDS)) begin
                frame_bcd_r <= bcd_in;
            end
            // Look one cycle ahead so the pulse lines up with the capture cycle
            frame_tick_r <= (prescaler_r == PRE_PENULT) && (idx_r == DIG_HUNDREDS);
            an_r         <= an_next_s;
            seg_r        <= seg_next_s;
            dp_r         <= 1'b1;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Scoreboard bench for bcd_sevenseg_scan with REFRESH_DIV=4 (12-cycle frames).
// The driver queues hand-computed digit slots; the monitor pops one per new anode slot.
module tb_bcd_sevenseg_scan;

    localparam int RD    = 4;
    localparam int FRAME = 3 * RD;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    logic        clk;
    logic        reset;
    logic [11:0] bcd_in;
    logic        blank_lz;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    typedef struct {
        logic [2:0] an;
        logic [6:0] seg;
        int         tag;
    } exp_t;

    typedef struct {
        logic [11:0] bcd;
        logic        blz;
        logic [6:0]  s0;
        logic [6:0]  s1;
        logic [6:0]  s2;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[9];
    int   errors = 0;
    int   checks = 0;
    int   edges  = 0;
    logic [2:0] prev_an = 3'b111;

    bcd_sevenseg_scan #(.REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_in     (bcd_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Non-reset rising edges since the last reset edge
    always @(posedge clk) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    // Monitor: per-cycle reset/anode/frame_tick checks and slot scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (edges == 0) begin
                checks++;
                if (an !== 3'b111 || seg !== SB || dp !== 1'b1 || frame_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: got an=%b seg=%b dp=%b ft=%b, want an=111 seg=1111111 dp=1 ft=0",
                             an, seg, dp, frame_tick);
                end
            end else begin
                checks++;
                if ($countones(~an) != 1 || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL one_anode: got an=%b dp=%b, want exactly one low anode and dp=1", an, dp);
                end
                checks++;
                if (frame_tick !== ((edges % FRAME) == (FRAME - 1))) begin
                    errors++;
                    $display("FAIL frame_tick: got %b at edge %0d, want %b", frame_tick, edges,
                             ((edges % FRAME) == (FRAME - 1)));
                end
            end
            if (an !== prev_an && an !== 3'b111) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL slot_unexpected: got an=%b seg=%b, want no further slot", an, seg);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (an !== mon_e.an || seg !== mon_e.seg) begin
                        errors++;
                        $display("FAIL slot_v%0d: got an=%b seg=%b, want an=%b seg=%b",
                                 mon_e.tag, an, seg, mon_e.an, mon_e.seg);
                    end
                end
            end
            prev_an = an;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push3(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input int tag);
        exp_q.push_back('{3'b110, s0, tag});
        exp_q.push_back('{3'b101, s1, tag});
        exp_q.push_back('{3'b011, s2, tag});
    endtask

    task automatic wait_ft(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            $display("FAIL frame_tick_timeout: got no pulse in %0d cycles, want one", budget);
            $fatal(1, "frame_tick timeout");
        end
    endtask

    // Driver: vectors are applied mid-frame; expectations are queued at each capture
    initial begin
        vecs[0] = '{12'h259, 1'b0, S9, S5, S2};
        vecs[1] = '{12'h009, 1'b1, S9, SB, SB};
        vecs[2] = '{12'h000, 1'b0, S0, S0, S0};
        vecs[3] = '{12'h000, 1'b1, S0, SB, SB};
        vecs[4] = '{12'h199, 1'b0, S9, S9, S1};
        vecs[5] = '{12'h200, 1'b0, S0, S0, S2};
        vecs[6] = '{12'h9A9, 1'b0, S9, SD, S9};
        vecs[7] = '{12'h050, 1'b1, S0, S5, SB};
        vecs[8] = '{12'hA00, 1'b1, S0, S0, SD};

        reset    = 1'b1;
        bcd_in   = 12'h259;
        blank_lz = 1'b0;
        push3(S0, S0, S0, 100);
        repeat (3) step();
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            bcd_in = vecs[i].bcd;
            wait_ft(3 * FRAME);
            blank_lz = vecs[i].blz;
            push3(vecs[i].s0, vecs[i].s1, vecs[i].s2, i);
            step();
            bcd_in = 12'h888;
            repeat (5) step();
        end

        // Now in the tens slot of the last frame: abort it with a one-cycle reset
        reset    = 1'b1;
        blank_lz = 1'b1;
        exp_q.delete();
        push3(S0, SB, SB, 101);
        step();
        reset  = 1'b0;
        bcd_in = 12'h347;
        wait_ft(3 * FRAME);
        push3(S7, S4, S3, 102);

        for (int i = 0; i < 3 * FRAME && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            $display("FAIL drain_timeout: got %0d slots pending, want 0", exp_q.size());
            $fatal(1, "scoreboard drain timeout");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_sevenseg_scan.md
BCD_SEVENSEG_SCAN -- requirements
Module: bcd_sevenseg_scan

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: bcd_in  input  12  three packed BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units; driven by the BCD incrementor output.
REQ-005 Port: blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-006 Port: an  output  3  digit anodes, active-low; an[0] units, an[1] tens, an[2] hundreds.
REQ-007 Port: seg  output  7  segments, active-low, order {g,f,e,d,c,b,a}.
REQ-008 Port: dp  output  1  decimal point, active-low; held at 1 (off).
REQ-009 Port: frame_tick  output  1  one-cycle pulse when a new bcd_in value is captured.

Function
REQ-010 Prescaler counts 0..REFRESH_DIV-1 and wraps; slot_tick is asserted in the cycle the count equals REFRESH_DIV-1.
REQ-011 Digit index idx (0..2) advances on slot_tick: 0->1->2->0; idx never takes value 3.
REQ-012 Shadow register frame_bcd loads bcd_in on slot_tick when idx==2, i.e. at the wrap to idx 0; frame_tick is asserted in the same cycle.
REQ-013 bcd_in changes outside the capture cycle have no effect on displayed digits (no tearing within a frame).
REQ-014 an, seg and dp are registered; each cycle they reflect idx and frame_bcd as held before that edge, giving 1 cycle of latency.
REQ-015 Exactly one an bit is low in every cycle after the first post-reset cycle, and it is an[idx].
REQ-016 Digit decode: 0-9 use standard patterns (0 = 1000000, 1 = 1111001, 8 = 0000000, 9 = 0010000, in {g..a}).
REQ-017 A nibble of 10-15 shows a dash (seg = 0111111); this pattern is never blanked.
REQ-018 With blank_lz=1, hundreds is blanked (seg = 1111111, anode still driven) when it equals 0.
REQ-019 With blank_lz=1, tens is blanked when hundreds and tens both equal 0; units is never blanked.
REQ-020 blank_lz is sampled live each cycle and is not frame-latched.
REQ-021 frame_tick period is exactly 3*REFRESH_DIV cycles in steady state.

Reset
REQ-022 While reset=1: prescaler=0, idx=0, frame_bcd=12'h000, an=3'b111, seg=7'b1111111, dp=1, frame_tick=0.
REQ-023 Reset asserted mid-frame aborts the scan; after release, the prescaler restarts from 0 and the first slot_tick falls REFRESH_DIV cycles after release.
REQ-024 In the first cycle after release, outputs show idx 0 of frame_bcd=000 (an=110, seg = "0"); bcd_in is first captured at the first idx-2 slot_tick.

Structure
REQ-025 Shared package/include holds: NUM_DIGITS=3, the segment constants SEG_BLANK and SEG_DASH, and the digit pattern table.
REQ-026 One sub-module: bcd_to_sevenseg (combinational, 4-bit BCD in, 7-bit active-low seg out, dash for 10-15); blanking logic lives in the parent.

Verification (bench uses REFRESH_DIV=4)
REQ-027 Hold reset 3 cycles, then release with bcd_in=12'h259 -> an sequence 110,101,011 each for 4 cycles; digits show 0,0,0 until the first frame_tick, then 9,5,2.
REQ-028 bcd_in=12'h009, blank_lz=1 -> units "9" (0010000); tens and hundreds seg=1111111 while their anodes are low.
REQ-029 bcd_in=12'h000, blank_lz=0 -> all three digits "0"; with blank_lz=1 -> only units "0" is shown.
REQ-030 Change bcd_in from 12'h199 to 12'h200 mid-frame -> the current frame continues showing 1,9,9 and the next frame shows 2,0,0; frame_tick pulses every 12 cycles.
REQ-031 bcd_in=12'h9A9 -> tens digit shows dash (0111111); other digits show 9.
REQ-032 Assert reset during idx=1 for 1 cycle -> an=111 during reset, then an=110 and frame_bcd=000; next frame_tick comes 12 cycles after release.
